// File: rtl/blc_cal_seq_pkg.sv
// blc_seq_pkg: shared definitions for the black-level calibration sequencer.
//   state_t / ST_*  : FSM state encoding
//   tmo_cnt_w()     : watchdog counter width for a given timeout
//   div_cnt_w()     : divider-wait counter width for a given latency
package blc_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT_FRM = 3'd1;
  localparam state_t ST_WAIT_DIV = 3'd2;
  localparam state_t ST_STROBE   = 3'd3;
  localparam state_t ST_PERIOD   = 3'd4;
  localparam state_t ST_ERR      = 3'd5;

  function automatic int tmo_cnt_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

  function automatic int div_cnt_w(input int div_lat);
    return $clog2(div_lat + 1);
  endfunction

endpackage

// File: rtl/blc_sof_watchdog.sv
// blc_sof_watchdog: counts cycles while enabled, cleared by any SOF.
//   clk_i, rst_i : clock, async active-high reset
//   en_i         : count enable (counter held at 0 when low)
//   clr_i        : clear (SOF seen this cycle)
//   tmo_o        : one-cycle pulse in the LIMIT-th enabled cycle without a clear
module blc_sof_watchdog #(
  parameter int LIMIT = 2**24,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tmo_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // A SOF in the same cycle rescues the wait; clear beats timeout.
  assign tmo_o = en_i & ~clr_i & (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                          cnt_q <= '0;
    else if (!en_i || clr_i || tmo_o)   cnt_q <= '0;
    else                                cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/blc_cal_seq.sv
// blc_cal_seq: sequencer for the black-level calibrator.
// Counts SOFs to find the measured frame, waits for the calibrator's divider,
// pulses the latch strobe (one-shot or every period_i frames), and reports
// status to software.
//   clk_i, rst_i      : clock, async active-high reset
//   sof_i             : start-of-frame pulse on the calibrator input
//   start_i, abort_i  : CSR pulses
//   mode_i, man_bl_i  : CSR manual/auto select and manual level
//   skip_frames_i     : frames discarded before the measured frame
//   period_i          : 0 one-shot, else frames between recalibrations
//   cur_bl_i          : calibrator's applied level
//   blc_mode_o, blc_man_bl_o, blc_cal_stb_o : to calibrator
//   busy_o, done_o, err_o, last_bl_o, cal_cnt_o : status to software
module blc_cal_seq
  import blc_seq_pkg::*;
#(
  parameter int PX_WIDTH      = 10,
  parameter int FRM_CNT_WIDTH = 8,
  parameter int DIV_LAT       = 40,
  parameter int TIMEOUT_CYC   = 2**24,
  parameter int CAL_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sof_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     mode_i,
  input  logic [PX_WIDTH-1:0]      man_bl_i,
  input  logic [FRM_CNT_WIDTH-1:0] skip_frames_i,
  input  logic [FRM_CNT_WIDTH-1:0] period_i,
  input  logic [PX_WIDTH-1:0]      cur_bl_i,
  output logic                     blc_mode_o,
  output logic [PX_WIDTH-1:0]      blc_man_bl_o,
  output logic                     blc_cal_stb_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [PX_WIDTH-1:0]      last_bl_o,
  output logic [CAL_CNT_WIDTH-1:0] cal_cnt_o
);

  localparam int FW1   = FRM_CNT_WIDTH + 1;
  localparam int TMO_W = tmo_cnt_w(TIMEOUT_CYC);
  localparam int DIV_W = div_cnt_w(DIV_LAT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_LAT - 1);

  state_t             state_q, state_d;
  logic [FW1-1:0]     frm_cnt_q, frm_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               err_q, err_d;
  logic               blc_mode_q, done_q;
  logic [PX_WIDTH-1:0] blc_man_q, last_bl_q;
  logic [CAL_CNT_WIDTH-1:0] cal_cnt_q;

  logic [FW1-1:0] frm_inc, close_tgt, per_tgt;
  logic           cancel, stb, wd_en, tmo;

  assign frm_inc   = frm_cnt_q + 1'b1;
  // Extra counter bit keeps skip+2 from wrapping at max skip.
  assign close_tgt = FW1'(skip_frames_i) + FW1'(2);
  assign per_tgt   = FW1'(period_i);
  assign cancel    = abort_i | mode_i;
  assign stb       = (state_q == ST_STROBE);

  // Enabled states are only entered from non-enabled states or on a SOF,
  // so en/clr alone restart the count on every state entry.
  assign wd_en = (state_q == ST_WAIT_FRM) || (state_q == ST_PERIOD);

  blc_sof_watchdog #(
    .LIMIT (TIMEOUT_CYC),
    .CNT_W (TMO_W)
  ) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (wd_en),
    .clr_i (sof_i),
    .tmo_o (tmo)
  );

  always_comb begin
    state_d   = state_q;
    frm_cnt_d = frm_cnt_q;
    div_cnt_d = div_cnt_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !mode_i && !abort_i) begin
          state_d   = ST_WAIT_FRM;
          frm_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      ST_WAIT_FRM: begin
        if (cancel) state_d = ST_IDLE;
        else if (sof_i) begin
          frm_cnt_d = frm_inc;
          // This SOF closes the measured frame; divider starts now.
          if (frm_inc == close_tgt) begin
            state_d   = ST_WAIT_DIV;
            div_cnt_d = '0;
          end
        end else if (tmo) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      ST_WAIT_DIV: begin
        if (cancel) state_d = ST_IDLE;
        else begin
          div_cnt_d = div_cnt_q + 1'b1;
          if (div_cnt_q == DIV_LAST) state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        // Strobe is already on the wire this cycle; cancel only skips PERIOD.
        if (cancel) state_d = ST_IDLE;
        else if (period_i != '0) begin
          state_d   = ST_PERIOD;
          frm_cnt_d = '0;
        end else state_d = ST_IDLE;
      end
      ST_PERIOD: begin
        if (cancel) state_d = ST_IDLE;
        else if (sof_i) begin
          frm_cnt_d = frm_inc;
          if (frm_inc == per_tgt) begin
            state_d   = ST_WAIT_FRM;
            frm_cnt_d = '0;
          end
        end else if (tmo) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end
      end
      ST_ERR: begin
        if (cancel) state_d = ST_IDLE;
        else if (start_i) begin
          state_d   = ST_WAIT_FRM;
          frm_cnt_d = '0;
          err_d     = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      frm_cnt_q  <= '0;
      div_cnt_q  <= '0;
      err_q      <= 1'b0;
      blc_mode_q <= 1'b0;
      blc_man_q  <= '0;
      done_q     <= 1'b0;
      last_bl_q  <= '0;
      cal_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      frm_cnt_q  <= frm_cnt_d;
      div_cnt_q  <= div_cnt_d;
      err_q      <= err_d;
      blc_mode_q <= mode_i;
      blc_man_q  <= man_bl_i;
      done_q     <= stb;
      if (stb) begin
        last_bl_q <= cur_bl_i;
        cal_cnt_q <= cal_cnt_q + 1'b1;
      end
    end
  end

  assign blc_mode_o    = blc_mode_q;
  assign blc_man_bl_o  = blc_man_q;
  assign blc_cal_stb_o = stb;
  assign busy_o        = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign last_bl_o     = last_bl_q;
  assign cal_cnt_o     = cal_cnt_q;

endmodule

// File: tb/tb_blc_cal_seq.sv
// tb_blc_cal_seq: self-checking bench for blc_cal_seq.
// CSR mux/start/abort table, directed multi-cycle sequences, and random SOF
// streams checked against an SOF-timeline model of when strobes must occur.
module tb_blc_cal_seq;

  localparam int PXW = 10, FW = 8, DL = 12, TO = 100, CW = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic sof_i = 0, start_i = 0, abort_i = 0, mode_i = 0;
  logic [PXW-1:0] man_bl_i = '0, cur_bl_i = '0;
  logic [FW-1:0]  skip_i = '0, period_i = '0;
  logic           blc_mode_o, blc_cal_stb_o, busy_o, done_o, err_o;
  logic [PXW-1:0] blc_man_bl_o, last_bl_o;
  logic [CW-1:0]  cal_cnt_o;

  always #5 clk = ~clk;

  blc_cal_seq #(
    .PX_WIDTH(PXW), .FRM_CNT_WIDTH(FW), .DIV_LAT(DL),
    .TIMEOUT_CYC(TO), .CAL_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sof_i(sof_i), .start_i(start_i),
    .abort_i(abort_i), .mode_i(mode_i), .man_bl_i(man_bl_i),
    .skip_frames_i(skip_i), .period_i(period_i), .cur_bl_i(cur_bl_i),
    .blc_mode_o(blc_mode_o), .blc_man_bl_o(blc_man_bl_o),
    .blc_cal_stb_o(blc_cal_stb_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .last_bl_o(last_bl_o), .cal_cnt_o(cal_cnt_o)
  );

  int errs = 0, checks = 0;
  int cyc = 0;
  int stb_q[$], sof_e[$], exp_q[$];
  int start_e = 0;
  logic [CW-1:0] exp_cal = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;
  always @(posedge clk) begin #2; cur_bl_i = PXW'($urandom); end

  // Strobe log plus done/last_bl follow-up checks.
  logic prev_stb = 0;
  logic [PXW-1:0] prev_bl = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stb || done_o) chk("done_after_stb", done_o, prev_stb);
      if (prev_stb) chk("last_bl", last_bl_o, prev_bl);
      prev_stb = blc_cal_stb_o;
      prev_bl  = cur_bl_i;
      if (blc_cal_stb_o) stb_q.push_back(cyc);
    end else prev_stb = 0;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sof();
    @(negedge clk); sof_i = 1; sof_e.push_back(cyc + 1);
    @(negedge clk); sof_i = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start_i = 1; start_e = cyc + 1;
    @(negedge clk); start_i = 0;
  endtask

  task automatic drive_sofs(input int n, input int gap);
    int g;
    for (int i = 0; i < n; i++) begin
      g = (gap == 0) ? int'($urandom_range(2, 60)) : gap;
      idle(g - 1);
      pulse_sof();
    end
  endtask

  task automatic finish_run();
    idle(DL + 5);
    if (busy_o) begin
      @(negedge clk); abort_i = 1;
      @(negedge clk); abort_i = 0;
    end
    idle(2);
  endtask

  // Strobe edges from the SOF timeline: the (skip+2)-th counted SOF closes the
  // measurement and the strobe follows DIV_LAT edges later; SOFs up to and
  // including the edge after the strobe are not counted, then period SOFs are
  // consumed before skip+2 more close the next measurement.
  function automatic void build_exp(input int s, input int skip, input int per);
    int th, need, cnt, t;
    exp_q.delete();
    th = s; need = skip + 2; cnt = 0;
    foreach (sof_e[i]) begin
      if (sof_e[i] > th) begin
        cnt++;
        if (cnt == need) begin
          t = sof_e[i] + DL;
          exp_q.push_back(t);
          if (per == 0) break;
          th = t + 1; cnt = 0; need = per + skip + 2;
        end
      end
    end
  endfunction

  task automatic check_run(input string tag);
    chk({tag, "_nstb"}, stb_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
      chk({tag, "_stb_cyc"}, stb_q[i], exp_q[i]);
    exp_cal = exp_cal + CW'(exp_q.size());
    chk({tag, "_cal_cnt"}, cal_cnt_o, exp_cal);
  endtask

  task automatic new_run();
    stb_q.delete(); sof_e.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stb"}, blc_cal_stb_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_mode"}, blc_mode_o, 0);
    chk({tag, "_man"}, blc_man_bl_o, 0);
    chk({tag, "_last"}, last_bl_o, 0);
    chk({tag, "_cnt"}, cal_cnt_o, 0);
  endtask

  typedef struct {
    logic mode; logic [PXW-1:0] man; logic start; logic abort;
    logic exp_busy; logic exp_mode; logic [PXW-1:0] exp_man;
  } vec_t;
  vec_t vt[9];

  initial begin
    #5000000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000};
    vt[1] = '{1'b1, 10'h055, 1'b1, 1'b0, 1'b0, 1'b1, 10'h055}; // manual: start ignored
    vt[2] = '{1'b0, 10'h3FF, 1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF}; // abort beats start
    vt[3] = '{1'b0, 10'h123, 1'b1, 1'b0, 1'b1, 1'b0, 10'h123};
    vt[4] = '{1'b0, 10'h200, 1'b1, 1'b0, 1'b1, 1'b0, 10'h200}; // start while busy
    vt[5] = '{1'b0, 10'h001, 1'b0, 1'b1, 1'b0, 1'b0, 10'h001};
    vt[6] = '{1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2AA};
    vt[7] = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000};
    vt[8] = '{1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1, 10'h155}; // manual cancels wait

    #12 chk_all_zero("reset");
    #11 rst = 0;

    // CSR mux and start/abort gating
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      mode_i = vt[i].mode; man_bl_i = vt[i].man;
      start_i = vt[i].start; abort_i = vt[i].abort;
      @(negedge clk);
      start_i = 0; abort_i = 0;
      chk("vec_busy", busy_o, vt[i].exp_busy);
      chk("vec_mode", blc_mode_o, vt[i].exp_mode);
      chk("vec_man", blc_man_bl_o, vt[i].exp_man);
    end
    mode_i = 0;
    idle(2);

    // 1: skip=2 one-shot
    new_run(); skip_i = 2; period_i = 0;
    do_start(); drive_sofs(5, 50); finish_run();
    build_exp(start_e, 2, 0);
    chk("t1_nstb", stb_q.size(), 1);
    if (stb_q.size() >= 1 && sof_e.size() >= 4) chk("t1_stb_at_sof4", stb_q[0], sof_e[3] + DL);
    chk("t1_busy", busy_o, 0);
    check_run("t1");

    // 2: skip=0 period=3
    new_run(); skip_i = 0; period_i = 3;
    do_start(); drive_sofs(10, 50); finish_run();
    build_exp(start_e, 0, 3);
    chk("t2_nstb", stb_q.size(), 2);
    if (stb_q.size() >= 2) begin
      chk("t2_stb0", stb_q[0], sof_e[1] + DL);
      chk("t2_stb1", stb_q[1], sof_e[6] + DL);
    end
    check_run("t2");

    // 3: abort in the last WAIT_DIV cycle, then abort+start in IDLE
    new_run(); skip_i = 0; period_i = 0;
    do_start(); idle(9); pulse_sof(); idle(9); pulse_sof();
    idle(DL - 1); abort_i = 1;
    @(negedge clk); abort_i = 0;
    idle(5);
    chk("t3_nstb", stb_q.size(), 0);
    chk("t3_busy", busy_o, 0);
    @(negedge clk); start_i = 1; abort_i = 1;
    @(negedge clk); start_i = 0; abort_i = 0;
    chk("t3_abort_start_busy", busy_o, 0);
    idle(DL + 5);
    chk("t3_nstb2", stb_q.size(), 0);

    // 4: manual mode during WAIT_DIV
    new_run();
    do_start(); idle(5); pulse_sof(); idle(5); pulse_sof(); idle(4);
    mode_i = 1; man_bl_i = 10'h055;
    @(negedge clk);
    chk("t4_mode", blc_mode_o, 1);
    chk("t4_man", blc_man_bl_o, 10'h055);
    chk("t4_busy", busy_o, 0);
    start_i = 1;
    @(negedge clk); start_i = 0;
    chk("t4_start_ignored", busy_o, 0);
    idle(DL + 5);
    chk("t4_nstb", stb_q.size(), 0);
    mode_i = 0;
    idle(2);

    // 5: timeout then recovery
    new_run();
    do_start();
    idle(99);
    chk("t5_err_before", err_o, 0);
    idle(1);
    chk("t5_err_at_100", err_o, 1);
    chk("t5_busy_err", busy_o, 0);
    idle(20);
    chk("t5_err_sticky", err_o, 1);
    skip_i = 1; period_i = 0;
    do_start();
    chk("t5_err_cleared", err_o, 0);
    chk("t5_busy_restart", busy_o, 1);
    drive_sofs(4, 30); finish_run();
    build_exp(start_e, 1, 0);
    chk("t5_nstb", stb_q.size(), 1);
    check_run("t5");

    // random SOF streams against the timeline model
    for (int r = 0; r < 6; r++) begin
      int sk, pe;
      sk = $urandom_range(0, 3); pe = $urandom_range(0, 3);
      new_run(); skip_i = FW'(sk); period_i = FW'(pe);
      do_start(); drive_sofs(int'($urandom_range(8, 20)), 0); finish_run();
      build_exp(start_e, sk, pe);
      check_run("rnd");
    end

    // 6: async reset in WAIT_FRM
    new_run(); skip_i = 1; period_i = 0; man_bl_i = 10'h155;
    do_start(); idle(5); pulse_sof(); idle(3);
    @(negedge clk); #2 rst = 1;
    #1 chk_all_zero("t6_async");
    @(negedge clk); #2 rst = 0;
    exp_cal = '0;
    new_run();
    pulse_sof(); idle(19); pulse_sof(); idle(19); pulse_sof();
    idle(DL + 5);
    chk("t6_nstb", stb_q.size(), 0);
    chk("t6_busy", busy_o, 0);
    chk("t6_cnt", cal_cnt_o, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
